dmem_arbiter: RTL

- Arbitrates the single-port data memory (256 x 16) between two requesters: the processor controller (core port) and a host loader/debug port (host port).
- Sits between the Controller/Datapath data-memory interface and the data RAM; lets a host preload or inspect D[] while the processor runs or is halted.
- Registered round-robin arbitration with per-port grant and read-data-valid pulses; host lock gives exclusive access for bulk program/data loads.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_rd_tracker.sv | 40 ++++
 rtl/dmem_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: port identifiers and the request bundle.
package dmem_pkg;

   localparam int AW = 8;
   localparam int DW = 16;

   typedef enum logic {
      PORT_CORE = 1'b0,
      PORT_HOST = 1'b1
   } port_id_e;

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/dmem_rd_tracker.sv
// Read-return tracker: valid/owner tag shift register, RD_LAT cycles deep.
// Latency RD_LAT from issue to rvalid; no backpressure, one tag accepted per cycle.
module dmem_rd_tracker
   import dmem_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     issue_vld,
   input  port_id_e issue_own,
   output logic     core_rvalid,
   output logic     host_rvalid,
   output logic     pending
);

   logic [RD_LAT-1:0] vld;
   port_id_e          own [RD_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            own[i] <= PORT_CORE;
         end
      end else begin
         vld[0] <= issue_vld;
         own[0] <= issue_own;
         for (int i = 1; i < RD_LAT; i++) begin
            vld[i] <= vld[i-1];
            own[i] <= own[i-1];
         end
      end
   end

   assign core_rvalid = vld[RD_LAT-1] && (own[RD_LAT-1] == PORT_CORE);
   assign host_rvalid = vld[RD_LAT-1] && (own[RD_LAT-1] == PORT_HOST);
   assign pending     = |vld;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data RAM between core and host; host lock excludes core.
// Latency: Req to Gnt 1 cycle, Gnt to RValid RD_LAT; requesters hold Req until Gnt (no other backpressure).
module dmem_arbiter #(
   parameter int AW         = dmem_pkg::AW,
   parameter int DW         = dmem_pkg::DW,
   parameter int RD_LAT     = 1,
   parameter int HOST_FIRST = 1
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          Core_Req,
   input  logic          Core_Wr,
   input  logic [AW-1:0] Core_Addr,
   input  logic [DW-1:0] Core_WData,
   output logic          Core_Gnt,
   output logic          Core_RValid,
   output logic [DW-1:0] Core_RData,
   input  logic          Host_Req,
   input  logic          Host_Wr,
   input  logic [AW-1:0] Host_Addr,
   input  logic [DW-1:0] Host_WData,
   input  logic          Host_Lock,
   output logic          Host_Gnt,
   output logic          Host_RValid,
   output logic [DW-1:0] Host_RData,
   output logic [AW-1:0] M_Addr,
   output logic          M_Wr,
   output logic [DW-1:0] M_WData,
   input  logic [DW-1:0] M_RData,
   output logic          Busy
);
   import dmem_pkg::*;

   port_id_e      rr_ptr;
   port_id_e      issue_own;
   logic          core_elig;
   logic          host_elig;
   logic          core_wins;
   logic          host_wins;
   logic          issue_rd;
   logic          rd_pending;
   logic [DW-1:0] core_rdata_q;
   logic [DW-1:0] host_rdata_q;

   // A request granted this cycle is consumed, so it sits out the next arbitration.
   assign core_elig = Core_Req && !Core_Gnt && !Host_Lock;
   assign host_elig = Host_Req && !Host_Gnt;
   assign host_wins = host_elig && (!core_elig || (rr_ptr == PORT_HOST));
   assign core_wins = core_elig && !host_wins;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Core_Gnt <= 1'b0;
         Host_Gnt <= 1'b0;
         M_Addr   <= '0;
         M_Wr     <= 1'b0;
         M_WData  <= '0;
         rr_ptr   <= (HOST_FIRST != 0) ? PORT_HOST : PORT_CORE;
      end else begin
         Core_Gnt <= core_wins;
         Host_Gnt <= host_wins;
         M_Wr     <= 1'b0;
         if (host_wins) begin
            M_Addr  <= Host_Addr;
            M_Wr    <= Host_Wr;
            M_WData <= Host_WData;
         end else if (core_wins) begin
            M_Addr  <= Core_Addr;
            M_Wr    <= Core_Wr;
            M_WData <= Core_WData;
         end
         if (core_elig && host_elig) begin
            rr_ptr <= (rr_ptr == PORT_HOST) ? PORT_CORE : PORT_HOST;
         end
      end
   end

   assign issue_rd  = (Core_Gnt || Host_Gnt) && !M_Wr;
   assign issue_own = Host_Gnt ? PORT_HOST : PORT_CORE;

   dmem_rd_tracker #(
      .RD_LAT (RD_LAT)
   ) u_rd_tracker (
      .clk         (Clk),
      .rst_n       (Reset_n),
      .issue_vld   (issue_rd),
      .issue_own   (issue_own),
      .core_rvalid (Core_RValid),
      .host_rvalid (Host_RValid),
      .pending     (rd_pending)
   );

   // Return data passes straight through in the RValid cycle, then is held.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         core_rdata_q <= '0;
         host_rdata_q <= '0;
      end else begin
         if (Core_RValid) core_rdata_q <= M_RData;
         if (Host_RValid) host_rdata_q <= M_RData;
      end
   end

   assign Core_RData = Core_RValid ? M_RData : core_rdata_q;
   assign Host_RData = Host_RValid ? M_RData : host_rdata_q;
   assign Busy       = Core_Gnt || Host_Gnt || rd_pending;

endmodule
